// File: rtl/rgb_pwm_capture.sv
// Samples three PWM pins and reports each channel's duty once two
// consecutive 2^WIDTH-cycle windows agree.
module rgb_pwm_capture #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       pins,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic [2:0]       stuck,
    output logic             locked
);

    typedef enum logic {ACQ, LOCKED} state_t;

    localparam logic [WIDTH-1:0] LAST = '1;

    logic [SYNC_STAGES-1:0][2:0] sync;
    logic [2:0]                  s;
    logic [WIDTH-1:0]            win;
    logic [2:0][WIDTH:0]         acc;
    logic [2:0][WIDTH:0]         prev;
    logic [2:0][WIDTH:0]         res;
    logic                        prev_ok;
    logic                        win_end;
    logic                        match;
    logic                        load;
    logic [2:0][WIDTH-1:0]       sat;
    logic [2:0]                  stuck_new;
    state_t                      state;
    state_t                      state_n;

    assign s       = sync[SYNC_STAGES-1];
    assign win_end = (win == LAST);
    assign match   = (res == prev);

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            res[c]       = acc[c] + (WIDTH+1)'(s[c]);
            // res tops out at exactly 2^WIDTH, so the MSB alone flags a stuck-high pin
            stuck_new[c] = res[c][WIDTH];
            sat[c]       = res[c][WIDTH] ? '1 : res[c][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            win     <= '0;
            acc     <= '0;
            prev    <= '0;
            prev_ok <= 1'b0;
        end else begin
            sync[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
            win <= win + 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (win == '0)
                    acc[c] <= (WIDTH+1)'(s[c]);
                else
                    acc[c] <= acc[c] + (WIDTH+1)'(s[c]);
            end
            if (win_end) begin
                prev    <= res;
                prev_ok <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ACQ;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == ACQ && win_end && match && prev_ok)
            state_n = LOCKED;
    end

    always_comb begin
        load   = 1'b0;
        locked = (state == LOCKED);
        if (win_end && match) begin
            unique case (state)
                ACQ:    load = prev_ok;
                LOCKED: load = ({sat[2], sat[1], sat[0], stuck_new}
                                != {b, g, r, stuck});
                default: load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            stuck <= '0;
            valid <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                r     <= sat[0];
                g     <= sat[1];
                b     <= sat[2];
                stuck <= stuck_new;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Randomised PWM stimulus checked every cycle against a window-sum model,
// plus literal checks of the headline scenarios.
module tb_rgb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] pins;
    logic [4:0] r, g, b;
    logic       valid;
    logic [2:0] stuck;
    logic       locked;

    rgb_pwm_capture #(.WIDTH(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .pins(pins),
        .r(r), .g(g), .b(b), .valid(valid),
        .stuck(stuck), .locked(locked)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int tcnt = 0;
    int duty[3] = '{0, 0, 0};
    logic [2:0] force_hi = 3'b000;
    logic [2:0] glitch = 3'b000;
    int vcnt = 0;
    int fv = -1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Driver-equivalent PWM: high while the period counter is below the duty.
    task automatic tick();
        logic [2:0] p;
        @(negedge clk);
        tcnt = (tcnt + 1) % 32;
        for (int c = 0; c < 3; c++)
            p[c] = force_hi[c] | (tcnt < duty[c]) | glitch[c];
        pins = p;
    endtask

    // Model: each window's result is the plain count of high samples the
    // logic saw, where the logic sees the pin two edges late (zero after reset).
    initial begin
        int e;
        logic [2:0] d1, d2;
        int sum[3], prv[3], res[3];
        bit pok, el, ev, match, diff;
        int er[3];
        logic [2:0] es;
        e = 0; d1 = 0; d2 = 0; pok = 0; el = 0; es = 0;
        for (int c = 0; c < 3; c++) begin
            sum[c] = 0; prv[c] = 0; er[c] = 0;
        end
        forever begin
            @(posedge clk);
            ev = 0;
            if (reset) begin
                e = 0; d1 = 0; d2 = 0; pok = 0; el = 0; es = 0;
                for (int c = 0; c < 3; c++) begin
                    sum[c] = 0; prv[c] = 0; er[c] = 0;
                end
            end else begin
                for (int c = 0; c < 3; c++)
                    sum[c] += int'(d2[c]);
                d2 = d1;
                d1 = pins;
                if (e % 32 == 31) begin
                    match = 1; diff = 0;
                    for (int c = 0; c < 3; c++) begin
                        res[c] = sum[c];
                        if (res[c] != prv[c]) match = 0;
                        if ((res[c] > 31 ? 31 : res[c]) != er[c]) diff = 1;
                        if ((res[c] == 32) != es[c]) diff = 1;
                    end
                    if (match && (el ? diff : pok)) begin
                        ev = 1; el = 1;
                        for (int c = 0; c < 3; c++) begin
                            er[c] = res[c] > 31 ? 31 : res[c];
                            es[c] = (res[c] == 32);
                        end
                    end
                    for (int c = 0; c < 3; c++) begin
                        prv[c] = res[c]; sum[c] = 0;
                    end
                    pok = 1;
                end
                e++;
            end
            #1;
            chk("r", int'(r), er[0]);
            chk("g", int'(g), er[1]);
            chk("b", int'(b), er[2]);
            chk("stuck", int'(stuck), int'(es));
            chk("valid", int'(valid), int'(ev));
            chk("locked", int'(locked), int'(el));
            if (valid) begin
                vcnt++;
                if (fv < 0) fv = e - 1;
            end
        end
    end

    initial begin
        reset = 1'b1;
        pins = 3'b000;
        repeat (3) tick();
        reset = 1'b0;

        // pins idle low: first report after edge 63, then silence
        repeat (96) tick();
        chk("first_valid_edge", fv, 63);
        chk("idle_valids", vcnt, 1);
        chk("idle_locked", int'(locked), 1);
        chk("idle_r", int'(r), 0);

        // r=10 g=0 b=31 at random phase
        tcnt = $urandom_range(0, 31);
        duty = '{10, 0, 31};
        vcnt = 0;
        repeat (98) tick();
        chk("pwm_valids", vcnt, 1);
        chk("pwm_r", int'(r), 10);
        chk("pwm_g", int'(g), 0);
        chk("pwm_b", int'(b), 31);
        chk("pwm_stuck", int'(stuck), 0);
        vcnt = 0;
        repeat (320) tick();
        chk("pwm_quiet", vcnt, 0);

        // red stuck high
        force_hi = 3'b001;
        repeat (98) tick();
        chk("stuck_r", int'(r), 31);
        chk("stuck_bits", int'(stuck), 1);
        force_hi = 3'b000;
        repeat (128) tick();
        chk("restore_r", int'(r), 10);

        // red 10 -> 20
        vcnt = 0;
        duty[0] = 20;
        repeat (98) tick();
        chk("change_valids", vcnt, 1);
        chk("change_r", int'(r), 20);

        // single-cycle glitch on green
        duty = '{20, 5, 20};
        repeat (128) tick();
        chk("glitch_pre_g", int'(g), 5);
        vcnt = 0;
        while (tcnt != 20) tick();
        glitch = 3'b010;
        tick();
        glitch = 3'b000;
        repeat (128) tick();
        chk("glitch_valids", vcnt, 0);
        chk("glitch_g", int'(g), 5);

        // one-cycle reset mid-window while locked, pins low around release
        repeat (7) tick();
        while (tcnt != 22) tick();
        reset = 1'b1;
        fv = -1;
        tick();
        chk("rst_r", int'(r), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_stuck", int'(stuck), 0);
        reset = 1'b0;
        repeat (70) tick();
        chk("reacq_edge", fv, 63);
        chk("reacq_r", int'(r), 20);

        // random duties and stuck pins
        for (int k = 0; k < 6; k++) begin
            duty = '{$urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31)};
            force_hi = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tcnt = $urandom_range(0, 31);
            repeat (130) tick();
            chk("rand_r", int'(r), force_hi[0] ? 31 : duty[0]);
            chk("rand_g", int'(g), force_hi[1] ? 31 : duty[1]);
            chk("rand_b", int'(b), force_hi[2] ? 31 : duty[2]);
            chk("rand_stuck", int'(stuck), int'(force_hi));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
